// File: rtl/regfile_pkg.sv
// Shared defaults, types and address-validity helper for the minicpu register file.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xlen_t;

  // An address is usable when it names a real register that is not the hardwired zero.
  function automatic logic addr_valid(input int unsigned addr, input int unsigned nregs,
                                      input int zero_reg);
    return (addr < nregs) && !((zero_reg != 0) && (addr == 0));
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: writes release, reserves claim, and a claim beats a release.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS    = NREGS_DEF,
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr0_ok,
  input  logic [AW-1:0]    wa0,
  input  logic             wr1_ok,
  input  logic [AW-1:0]    wa1,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  output logic             rsv_ok,
  output logic [NREGS-1:0] busy
);

  logic [NREGS-1:0] busy_nxt;

  assign rsv_ok = rsv_en && addr_valid(32'(rsv_addr), NREGS, ZERO_REG);

  always_comb begin
    busy_nxt = busy;
    for (int i = 0; i < NREGS; i++) begin
      if ((wr0_ok && (32'(wa0) == i)) || (wr1_ok && (32'(wa1) == i)))
        busy_nxt[i] = 1'b0;
      // a new producer claiming the register overrides the old one's release
      if (rsv_ok && (32'(rsv_addr) == i))
        busy_nxt[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NREAD combinational reads, two prioritised writes, busy scoreboard.
// Define REGFILE_BYPASS_EN for write-first forwarding onto the read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREAD*AW-1:0]   ra,
  output logic [NREAD*XLEN-1:0] rd,
  output logic [NREAD-1:0]      rbusy,
  input  logic                  we0,
  input  logic [AW-1:0]         wa0,
  input  logic [XLEN-1:0]       wd0,
  input  logic                  we1,
  input  logic [AW-1:0]         wa1,
  input  logic [XLEN-1:0]       wd1,
  input  logic                  rsv_en,
  input  logic [AW-1:0]         rsv_addr,
  output logic                  rsv_ok
);

  logic [XLEN-1:0]  mem [NREGS];
  logic [NREGS-1:0] busy;
  logic             wr0_ok;
  logic             wr1_ok;
  logic [AW-1:0]    ra_k;

  assign wr0_ok = we0 && addr_valid(32'(wa0), NREGS, ZERO_REG);
  assign wr1_ok = we1 && addr_valid(32'(wa1), NREGS, ZERO_REG);

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr0_ok   (wr0_ok),
    .wa0      (wa0),
    .wr1_ok   (wr1_ok),
    .wa1      (wa1),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rsv_ok   (rsv_ok),
    .busy     (busy)
  );

  // port 1 takes precedence when both ports hit the same register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wr1_ok && (32'(wa1) == i))      mem[i] <= wd1;
        else if (wr0_ok && (32'(wa0) == i)) mem[i] <= wd0;
      end
    end
  end

  always_comb begin
    rd    = '0;
    rbusy = '0;
    ra_k  = '0;
    for (int k = 0; k < NREAD; k++) begin
      ra_k = ra[k*AW +: AW];
      if (addr_valid(32'(ra_k), NREGS, ZERO_REG)) begin
        rd[k*XLEN +: XLEN] = mem[ra_k];
        rbusy[k]           = busy[ra_k];
      end
`ifdef REGFILE_BYPASS_EN
      // a same-cycle reserve keeps the register busy even while its old value forwards
      if (wr1_ok && (wa1 == ra_k)) begin
        rd[k*XLEN +: XLEN] = wd1;
        if (!(rsv_ok && (rsv_addr == ra_k))) rbusy[k] = 1'b0;
      end else if (wr0_ok && (wa0 == ra_k)) begin
        rd[k*XLEN +: XLEN] = wd0;
        if (!(rsv_ok && (rsv_addr == ra_k))) rbusy[k] = 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp (NREGS=24, two read ports) with an array-based reference model.
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 24;
  localparam int NREAD = 2;
  localparam int AW    = 5;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREAD*AW-1:0]   ra;
  logic [NREAD*XLEN-1:0] rd;
  logic [NREAD-1:0]      rbusy;
  logic                  we0, we1, rsv_en;
  logic [AW-1:0]         wa0, wa1, rsv_addr;
  logic [XLEN-1:0]       wd0, wd1;
  logic                  rsv_ok;
  logic [AW-1:0]         ra0, ra1;

  assign ra = {ra1, ra0};

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_m  [NREGS];
  bit          busy_m [NREGS];

  regfile_mp #(
    .XLEN     (XLEN),
    .NREGS    (NREGS),
    .NREAD    (NREAD),
    .ZERO_REG (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra       (ra),
    .rd       (rd),
    .rbusy    (rbusy),
    .we0      (we0),
    .wa0      (wa0),
    .wd0      (wd0),
    .we1      (we1),
    .wa1      (wa1),
    .wd1      (wd1),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rsv_ok   (rsv_ok)
  );

  always #5 clk = ~clk;

  function automatic bit vld(input logic [AW-1:0] a);
    return (a < 5'(NREGS)) && (a != '0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NREGS; i++) begin
      mem_m[i]  = '0;
      busy_m[i] = 1'b0;
    end
  endtask

  task automatic exp_read(input logic [AW-1:0] a, output logic [31:0] d, output logic b);
    d = '0;
    b = 1'b0;
    if (vld(a)) begin
      d = mem_m[a];
      b = busy_m[a];
    end
`ifdef REGFILE_BYPASS_EN
    if (we1 && vld(wa1) && wa1 == a) begin
      d = wd1;
      if (!(rsv_en && vld(rsv_addr) && rsv_addr == a)) b = 1'b0;
    end else if (we0 && vld(wa0) && wa0 == a) begin
      d = wd0;
      if (!(rsv_en && vld(rsv_addr) && rsv_addr == a)) b = 1'b0;
    end
`endif
  endtask

  // Compare every output against the model for the inputs currently driven.
  task automatic check_all(input string tag);
    logic [31:0] d;
    logic        b;
    #1;
    exp_read(ra0, d, b);
    chk({tag, ":rd0"}, rd[31:0], d);
    chk({tag, ":rbusy0"}, {31'b0, rbusy[0]}, {31'b0, b});
    exp_read(ra1, d, b);
    chk({tag, ":rd1"}, rd[63:32], d);
    chk({tag, ":rbusy1"}, {31'b0, rbusy[1]}, {31'b0, b});
    chk({tag, ":rsv_ok"}, {31'b0, rsv_ok}, {31'b0, rsv_en && vld(rsv_addr)});
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (we0 && vld(wa0)) begin mem_m[wa0] = wd0; busy_m[wa0] = 1'b0; end
      if (we1 && vld(wa1)) begin mem_m[wa1] = wd1; busy_m[wa1] = 1'b0; end
      if (rsv_en && vld(rsv_addr)) busy_m[rsv_addr] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    we0 = 0; wa0 = '0; wd0 = '0;
    we1 = 0; wa1 = '0; wd1 = '0;
    rsv_en = 0; rsv_addr = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    ra0 = '0;
    ra1 = '0;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_all("reset_state");

    // reset clears a written register immediately and discards writes while held
    we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF; ra0 = 5;
    tick();
    idle();
    chk("r5_written", rd[31:0], 32'hDEADBEEF);
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("rst_async_rd", rd[31:0], 32'h0);
    chk("rst_async_busy", {31'b0, rbusy[0]}, 32'h0);
    we0 = 1; wa0 = 5; wd0 = 32'h55; rsv_en = 1; rsv_addr = 5;
    tick();
    idle();
    #1;
    chk("rst_discard_rd", rd[31:0], 32'h0);
    chk("rst_discard_busy", {31'b0, rbusy[0]}, 32'h0);
    rst_n = 1'b1;
    we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF;
    tick();
    idle();
    chk("r5_after_rst", rd[31:0], 32'hDEADBEEF);

    // hardwired zero register
    we0 = 1; wa0 = 0; wd0 = 32'h1234; rsv_en = 1; rsv_addr = 0; ra0 = 0;
    check_all("zero_req");
    chk("zero_rsv_ok", {31'b0, rsv_ok}, 32'h0);
    tick();
    idle();
    check_all("zero_after");
    chk("zero_rd", rd[31:0], 32'h0);

    // same-address write collision
    we0 = 1; wa0 = 7; wd0 = 32'h11111111;
    we1 = 1; wa1 = 7; wd1 = 32'h22222222;
    ra0 = 7;
    tick();
    idle();
    check_all("collision");
    chk("collision_val", rd[31:0], 32'h22222222);

    // scoreboard reserve / write+reserve / release
    rsv_en = 1; rsv_addr = 3; ra0 = 3;
    tick();
    idle();
    check_all("rsv_r3");
    chk("rsv_r3_busy", {31'b0, rbusy[0]}, 32'h1);
    we0 = 1; wa0 = 3; wd0 = 32'hA5; rsv_en = 1; rsv_addr = 3;
    check_all("wr_rsv_r3_now");
    tick();
    idle();
    check_all("wr_rsv_r3");
    chk("wr_rsv_r3_busy", {31'b0, rbusy[0]}, 32'h1);
    chk("wr_rsv_r3_val", rd[31:0], 32'hA5);
    we1 = 1; wa1 = 3; wd1 = 32'hB6;
    check_all("rel_r3_now");
    tick();
    idle();
    check_all("rel_r3");
    chk("rel_r3_busy", {31'b0, rbusy[0]}, 32'h0);

    // same-cycle read of a register being written
    we0 = 1; wa0 = 9; wd0 = 32'hCAFEF00D; ra1 = 9;
    check_all("byp_now");
`ifdef REGFILE_BYPASS_EN
    chk("byp_now_val", rd[63:32], 32'hCAFEF00D);
`else
    chk("byp_now_val", rd[63:32], 32'h0);
`endif
    tick();
    idle();
    chk("byp_next_val", rd[63:32], 32'hCAFEF00D);

    // out-of-range address
    we0 = 1; wa0 = 30; wd0 = 32'hFFFFFFFF; rsv_en = 1; rsv_addr = 30; ra1 = 30;
    check_all("oor_req");
    chk("oor_rsv_ok", {31'b0, rsv_ok}, 32'h0);
    chk("oor_rd", rd[63:32], 32'h0);
    tick();
    idle();
    for (int i = 0; i < NREGS; i++) begin
      ra0 = AW'(i);
      check_all("oor_sweep");
    end

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      we0 = ($urandom_range(0, 1) == 1);
      wa0 = AW'($urandom_range(0, 31));
      wd0 = $urandom;
      we1 = ($urandom_range(0, 2) == 0);
      wa1 = ($urandom_range(0, 3) == 0) ? wa0 : AW'($urandom_range(0, 31));
      wd1 = $urandom;
      rsv_en = ($urandom_range(0, 2) == 0);
      rsv_addr = ($urandom_range(0, 3) == 0) ? wa0 : AW'($urandom_range(0, 31));
      ra0 = AW'($urandom_range(0, 31));
      ra1 = ($urandom_range(0, 3) == 0) ? wa1 : AW'($urandom_range(0, 31));
      check_all("rand");
      tick();
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
